// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op_e     : operation encodings driven on muldiv_unit.op
//   - *_CYCLES_DEF : default busy durations for MULT/MULTU and DIV/DIVU
//   - mdu_decode() : maps a MIPS opcode/funct pair to a muldiv operation;
//                    the EX-stage decode uses the same function.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MTHI     = 6'h11;
    localparam logic [5:0] FN_MTLO     = 6'h13;
    localparam logic [5:0] FN_MULT     = 6'h18;
    localparam logic [5:0] FN_MULTU    = 6'h19;
    localparam logic [5:0] FN_DIV      = 6'h1A;
    localparam logic [5:0] FN_DIVU     = 6'h1B;

    typedef struct packed {
        logic    is_mdu;
        mdu_op_e op;
    } mdu_dec_t;

    function automatic mdu_dec_t mdu_decode(input logic [5:0] opcode,
                                            input logic [5:0] funct);
        mdu_dec_t d;
        d.is_mdu = 1'b0;
        d.op     = MDU_MULT;
        if (opcode == OPC_SPECIAL) begin
            d.is_mdu = 1'b1;
            case (funct)
                FN_MULT:  d.op = MDU_MULT;
                FN_MULTU: d.op = MDU_MULTU;
                FN_DIV:   d.op = MDU_DIV;
                FN_DIVU:  d.op = MDU_DIVU;
                FN_MTHI:  d.op = MDU_MTHI;
                FN_MTLO:  d.op = MDU_MTLO;
                default:  d.is_mdu = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit holding the architectural
// HI/LO registers. Results are computed behaviourally at accept and held in
// pending registers; a down-counter models latency and the pending values
// are committed on its terminal count.
//
// Ports
//   clk      in   pipeline clock
//   reset_n  in   synchronous active-low reset
//   start    in   muldiv-class instruction valid in EX
//   op       in   [2:0] operation (mdu_op_e encodings, 6-7 reserved)
//   src_a    in   [31:0] rs value
//   src_b    in   [31:0] rt value
//   busy     out  multi-cycle operation in progress (registered)
//   hi       out  [31:0] HI register
//   lo       out  [31:0] LO register
//
// State        | meaning
// cnt == 0     | idle, start accepted
// cnt == 1     | last busy cycle; commit edge, start also accepted
// cnt  > 1     | busy, start ignored
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_commit_q, pend_commit_d;

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic        [63:0] prod_u;
    logic               div_zero, div_ovf;
    logic        [31:0] div_b_safe;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;
    logic               terminal, can_accept;

    assign a_sx   = {{32{src_a[31]}}, src_a};
    assign b_sx   = {{32{src_b[31]}}, src_b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'h0, src_a} * {32'h0, src_b};

    // The divisor is forced to 1 for divide-by-zero (result discarded) and for
    // the INT_MIN / -1 case, whose wrapped result is substituted explicitly.
    assign div_zero   = (src_b == 32'h0);
    assign div_ovf    = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    assign div_b_safe = (div_zero || div_ovf) ? 32'h1 : src_b;
    assign quot_s     = div_ovf ? $signed(src_a) : ($signed(src_a) / $signed(div_b_safe));
    assign rem_s      = div_ovf ? 32'sh0 : ($signed(src_a) % $signed(div_b_safe));
    assign quot_u     = src_a / div_b_safe;
    assign rem_u      = src_a % div_b_safe;

    // The terminal edge of one operation is also the accepting edge of the
    // next, so back-to-back operations run with no idle cycle.
    assign terminal   = (cnt_q == CNT_ONE);
    assign can_accept = (cnt_q == '0) || terminal;

    always_comb begin
        cnt_d         = cnt_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        pend_hi_d     = pend_hi_q;
        pend_lo_d     = pend_lo_q;
        pend_commit_d = pend_commit_q;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
            if (terminal) begin
                pend_commit_d = 1'b0;
                if (pend_commit_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end

        // Placed after the commit so a same-edge MTHI/MTLO, being younger,
        // overrides the committing result.
        if (start && can_accept) begin
            case (op)
                MDU_MULT: begin
                    pend_hi_d     = prod_s[63:32];
                    pend_lo_d     = prod_s[31:0];
                    pend_commit_d = 1'b1;
                    cnt_d         = MULT_LOAD;
                end
                MDU_MULTU: begin
                    pend_hi_d     = prod_u[63:32];
                    pend_lo_d     = prod_u[31:0];
                    pend_commit_d = 1'b1;
                    cnt_d         = MULT_LOAD;
                end
                MDU_DIV: begin
                    pend_hi_d     = rem_s;
                    pend_lo_d     = quot_s;
                    pend_commit_d = !div_zero;
                    cnt_d         = DIV_LOAD;
                end
                MDU_DIVU: begin
                    pend_hi_d     = rem_u;
                    pend_lo_d     = quot_u;
                    pend_commit_d = !div_zero;
                    cnt_d         = DIV_LOAD;
                end
                MDU_MTHI: hi_d = src_a;
                MDU_MTLO: lo_d = src_a;
                default: ;
            endcase
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            hi_q          <= 32'h0;
            lo_q          <= 32'h0;
            pend_hi_q     <= 32'h0;
            pend_lo_q     <= 32'h0;
            pend_commit_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            pend_hi_q     <= pend_hi_d;
            pend_lo_q     <= pend_lo_d;
            pend_commit_q <= pend_commit_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed cases followed by random operations,
// all checked against an arithmetic reference model of HI/LO and latency.
module tb_muldiv_unit;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_cmp;
    int          n_bad;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: architectural result and latency of one operation.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output bit wh, output bit wl,
                                  output logic [31:0] nh, output logic [31:0] nl);
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        lat = 0; wh = 0; wl = 0; nh = '0; nl = '0;
        case (o)
            3'd0: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; wh = 1; wl = 1; lat = MC; end
            3'd1: begin pu = ua * ub; nh = pu[63:32]; nl = pu[31:0]; wh = 1; wl = 1; lat = MC; end
            3'd2: begin
                lat = DC;
                if (b != 0) begin nl = 32'(sa / sb); nh = 32'(sa % sb); wh = 1; wl = 1; end
            end
            3'd3: begin
                lat = DC;
                if (b != 0) begin nl = 32'(ua / ub); nh = 32'(ua % ub); wh = 1; wl = 1; end
            end
            3'd4: begin wh = 1; nh = a; end
            3'd5: begin wl = 1; nl = a; end
            default: ;
        endcase
    endfunction

    // Issues one op at the current negedge. For multi-cycle ops it returns at
    // the negedge of the last busy cycle, so the caller may chain another op.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        bit          wh, wl;
        logic [31:0] nh, nl;
        model(o, a, b, lat, wh, wl, nh, nl);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
        if (lat == 0) begin
            if (wh) exp_hi = nh;
            if (wl) exp_lo = nl;
            chk("mt_busy", {31'h0, busy}, 32'd0);
            chk("mt_hi", hi, exp_hi);
            chk("mt_lo", lo, exp_lo);
        end else begin
            for (int i = 1; i <= lat; i++) begin
                chk("busy_window", {31'h0, busy}, 32'd1);
                chk("hi_held", hi, exp_hi);
                chk("lo_held", lo, exp_lo);
                if (i < lat) @(negedge clk);
            end
            if (wh) exp_hi = nh;
            if (wl) exp_lo = nl;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        chk("idle_busy", {31'h0, busy}, 32'd0);
        chk("result_hi", hi, exp_hi);
        chk("result_lo", lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        n_cmp = 0; n_bad = 0;
        exp_hi = '0; exp_lo = '0;
        reset_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'h0, busy}, 32'd0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        reset_n = 1'b1;

        run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        settle();
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);

        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        settle();
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op(MDU_DIVU, 32'd100, 32'd7);
        settle();
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd14);

        run_op(MDU_MTHI, 32'h1234_5678, 32'h0);
        run_op(MDU_MTLO, 32'h1234_5678, 32'h0);
        run_op(MDU_DIVU, 32'd55, 32'h0);
        settle();
        chk("div0_hi", hi, 32'h1234_5678);
        chk("div0_lo", lo, 32'h1234_5678);

        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        settle();
        chk("ovf_hi", hi, 32'h0);
        chk("ovf_lo", lo, 32'h8000_0000);

        // start while busy: MTLO on busy cycle 2 must be ignored
        start = 1'b1; op = MDU_MULT; src_a = 32'd2; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= MC; i++) begin
            chk("ign_busy", {31'h0, busy}, 32'd1);
            chk("ign_lo_held", lo, exp_lo);
            if (i == 2) begin start = 1'b1; op = MDU_MTLO; src_a = 32'h0000_DEAD; end
            else start = 1'b0;
            if (i < MC) @(negedge clk);
        end
        start = 1'b0;
        exp_hi = 32'h0; exp_lo = 32'd6;
        settle();
        chk("ign_lo", lo, 32'd6);
        chk("ign_hi", hi, 32'd0);

        // reset mid-op discards the in-flight divide
        run_op(MDU_MTHI, 32'hA5A5_A5A5, 32'h0);
        run_op(MDU_MTLO, 32'h5A5A_5A5A, 32'h0);
        start = 1'b1; op = MDU_DIV; src_a = 32'hFFFF_FF9C; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_hi = '0; exp_lo = '0;
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        for (int i = 0; i < DC + 2; i++) begin
            @(negedge clk);
            chk("rst_no_commit_busy", {31'h0, busy}, 32'd0);
            chk("rst_no_commit_hi", hi, 32'h0);
            chk("rst_no_commit_lo", lo, 32'h0);
        end

        for (int n = 0; n < 60; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 9));
                2: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(ro, ra, rb);
            if ($urandom_range(0, 1) == 1) settle();
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
